// File: rtl/demux4_buf_pkg.sv
// Shared constants for the buffered 1-to-4 word distributor.
package demux4_buf_pkg;

  localparam int N_CH = 4;

  localparam logic [1:0] CH_A = 2'b00;
  localparam logic [1:0] CH_B = 2'b01;
  localparam logic [1:0] CH_C = 2'b10;
  localparam logic [1:0] CH_D = 2'b11;

  localparam int CNT_W = 16;

endpackage

// File: rtl/demux4_buf_fifo.sv
// Single-channel DEPTH-entry FIFO; the head output holds the last popped word while empty.
module demux4_fifo #(
  parameter int NB    = 32,
  parameter int DEPTH = 2
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [NB-1:0] i_data,
  output logic          o_full,
  output logic          o_empty,
  output logic [NB-1:0] o_head
);

  localparam int PW = $clog2(DEPTH);

  logic [NB-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic [NB-1:0] last_q;
  logic          push_ok;
  logic          pop_ok;

  assign o_full  = (count == (PW+1)'(DEPTH));
  assign o_empty = (count == '0);
  assign push_ok = i_push && !o_full;
  assign pop_ok  = i_pop && !o_empty;
  assign o_head  = o_empty ? last_q : mem[rd_ptr];

  // NOTE: storage is cleared on reset because the head word of an empty
  // channel is visible on the outputs and must read 0 after reset.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last_q <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= i_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        last_q <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/demux4_buf.sv
// Buffered 1-to-4 word distributor with independent per-channel FIFOs.
// Optional per-channel delivered-word counters on o_count when DEMUX4_CNT_EN is defined.
module demux4_buf
  import demux4_buf_pkg::*;
#(
  parameter int NB        = 32,
  parameter int NB_SELECT = 2,
  parameter int DEPTH     = 2
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_valid,
  input  logic [NB_SELECT-1:0] i_SEL,
  input  logic [NB-1:0]        i_data,
  output logic                 o_ready,
  input  logic [N_CH-1:0]      i_ready,
  output logic [N_CH-1:0]      o_valid,
  output logic [NB-1:0]        o_data_A,
  output logic [NB-1:0]        o_data_B,
  output logic [NB-1:0]        o_data_C,
  output logic [NB-1:0]        o_data_D
`ifdef DEMUX4_CNT_EN
  ,
  output logic [N_CH*CNT_W-1:0] o_count
`endif
);

  logic [N_CH-1:0] full;
  logic [N_CH-1:0] empty;
  logic [N_CH-1:0] push;
  logic [N_CH-1:0] pop;
  logic [NB-1:0]   head [N_CH];

  // Ready depends only on select and stored state, never on consumer ready.
  assign o_ready = !full[i_SEL];
  assign o_valid = ~empty;
  assign pop     = o_valid & i_ready;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    assign push[k] = i_valid && o_ready && (i_SEL == NB_SELECT'(k));

    demux4_fifo #(
      .NB    (NB),
      .DEPTH (DEPTH)
    ) u_fifo (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_push  (push[k]),
      .i_pop   (pop[k]),
      .i_data  (i_data),
      .o_full  (full[k]),
      .o_empty (empty[k]),
      .o_head  (head[k])
    );
  end

  assign o_data_A = head[CH_A];
  assign o_data_B = head[CH_B];
  assign o_data_C = head[CH_C];
  assign o_data_D = head[CH_D];

`ifdef DEMUX4_CNT_EN
  logic [CNT_W-1:0] cnt [N_CH];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int k = 0; k < N_CH; k++) cnt[k] <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++)
        if (pop[k]) cnt[k] <= cnt[k] + 1'b1;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_cnt
    assign o_count[k*CNT_W +: CNT_W] = cnt[k];
  end
`endif

endmodule

// File: tb/tb_demux4_buf.sv
// Scoreboard bench for demux4_buf: per-channel expected-word queues checked against every output each cycle.
module tb_demux4_buf;
  import demux4_buf_pkg::*;

  localparam int NB    = 32;
  localparam int DEPTH = 2;

  logic          i_clk = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_valid = 1'b0;
  logic [1:0]    i_SEL = 2'b00;
  logic [NB-1:0] i_data = '0;
  logic [3:0]    i_ready = 4'b0000;
  logic          o_ready;
  logic [3:0]    o_valid;
  logic [NB-1:0] o_data_A, o_data_B, o_data_C, o_data_D;
`ifdef DEMUX4_CNT_EN
  logic [63:0]   o_count;
  logic [15:0]   cnt_m [4];
`endif

  logic [NB-1:0] data_out [4];
  logic [NB-1:0] q [4][$];
  logic [NB-1:0] last [4];

  int unsigned n_vec  = 0;
  int unsigned n_fail = 0;

  demux4_buf #(.NB(NB), .NB_SELECT(2), .DEPTH(DEPTH)) dut (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_valid  (i_valid),
    .i_SEL    (i_SEL),
    .i_data   (i_data),
    .o_ready  (o_ready),
    .i_ready  (i_ready),
    .o_valid  (o_valid),
    .o_data_A (o_data_A),
    .o_data_B (o_data_B),
    .o_data_C (o_data_C),
    .o_data_D (o_data_D)
`ifdef DEMUX4_CNT_EN
    ,
    .o_count  (o_count)
`endif
  );

  always #5 i_clk = ~i_clk;

  assign data_out[0] = o_data_A;
  assign data_out[1] = o_data_B;
  assign data_out[2] = o_data_C;
  assign data_out[3] = o_data_D;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < 4; k++) begin
      q[k].delete();
      last[k] = '0;
`ifdef DEMUX4_CNT_EN
      cnt_m[k] = '0;
`endif
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [3:0] ev;
    for (int k = 0; k < 4; k++) ev[k] = (q[k].size() != 0);
    check({tag, ".valid"}, 64'(o_valid), 64'(ev));
    check({tag, ".ready"}, 64'(o_ready), 64'(q[i_SEL].size() < DEPTH));
    for (int k = 0; k < 4; k++)
      check($sformatf("%s.data%0d", tag, k), 64'(data_out[k]),
            64'((q[k].size() != 0) ? q[k][0] : last[k]));
`ifdef DEMUX4_CNT_EN
    check({tag, ".count"}, o_count, {cnt_m[3], cnt_m[2], cnt_m[1], cnt_m[0]});
`endif
  endtask

  // One cycle: drive at negedge, check before the edge, advance the model at the edge.
  task automatic step(input string tag, input logic valid, input logic [1:0] sel,
                      input logic [NB-1:0] data, input logic [3:0] rdy, output bit acc);
    bit [3:0] pops;
    i_valid = valid;
    i_SEL   = sel;
    i_data  = data;
    i_ready = rdy;
    #1;
    check_outputs(tag);
    for (int k = 0; k < 4; k++) pops[k] = (q[k].size() != 0) && rdy[k];
    acc = valid && (q[sel].size() < DEPTH);
    @(posedge i_clk);
    for (int k = 0; k < 4; k++)
      if (pops[k]) begin
        last[k] = q[k].pop_front();
`ifdef DEMUX4_CNT_EN
        cnt_m[k] = cnt_m[k] + 16'd1;
`endif
      end
    if (acc) q[sel].push_back(data);
    @(negedge i_clk);
  endtask

  task automatic push_hold(input string tag, input logic [1:0] sel,
                           input logic [NB-1:0] data, input logic [3:0] rdy);
    bit acc = 1'b0;
    int tries = 0;
    while (!acc && tries < 16) begin
      step(tag, 1'b1, sel, data, rdy, acc);
      tries++;
    end
    if (!acc) check({tag, ".timeout"}, 64'd0, 64'd1);
  endtask

  task automatic idle(input string tag, input logic [3:0] rdy, input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(tag, 1'b0, 2'b00, '0, rdy, acc);
  endtask

  task automatic do_reset(input string tag);
    i_valid = 1'b0;
    i_reset = 1'b1;
    clear_model();
    #2;
    check_outputs(tag);
    @(posedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b0;
  endtask

  initial begin
    bit acc;
    clear_model();
    @(negedge i_clk);
    @(negedge i_clk);
    do_reset("rst0");

    // Single word to channel C, nothing draining.
    step("c_push", 1'b1, CH_C, 32'hDEAD_BEEF, 4'b0000, acc);
    step("c_seen", 1'b0, CH_C, '0, 4'b0000, acc);
    check("c_head", 64'(o_data_C), 64'h0000_0000_DEAD_BEEF);
    idle("c_drain", 4'b0100, 2);

    // Fill A, third word blocked until the consumer drains.
    step("a1", 1'b1, CH_A, 32'h1, 4'b0000, acc);
    step("a2", 1'b1, CH_A, 32'h2, 4'b0000, acc);
    step("a3_blk", 1'b1, CH_A, 32'h3, 4'b0000, acc);
    check("a3_refused", 64'(acc), 64'd0);
    push_hold("a3", CH_A, 32'h3, 4'b0001);
    idle("a_drain", 4'b0001, 3);

    // B full with simultaneous pop: push refused, then accepted next cycle.
    step("b1", 1'b1, CH_B, 32'hB1, 4'b0000, acc);
    step("b2", 1'b1, CH_B, 32'hB2, 4'b0000, acc);
    step("b_full_pop", 1'b1, CH_B, 32'hB3, 4'b0010, acc);
    check("b_refused", 64'(acc), 64'd0);
    step("b_accept", 1'b1, CH_B, 32'hB3, 4'b0010, acc);
    check("b_accepted", 64'(acc), 64'd1);
    idle("b_drain", 4'b0010, 3);

    // Round-robin A..D with all consumers ready.
    for (int i = 0; i < 8; i++) begin
      step("rr", 1'b1, 2'(i), 32'h100 + 32'(i), 4'b1111, acc);
      check("rr_acc", 64'(acc), 64'd1);
    end
    idle("rr_drain", 4'b1111, 2);

    // Reset mid-transfer with C holding two words and D one.
    step("pre_c1", 1'b1, CH_C, 32'hC1, 4'b0000, acc);
    step("pre_c2", 1'b1, CH_C, 32'hC2, 4'b0000, acc);
    step("pre_d1", 1'b1, CH_D, 32'hD1, 4'b0000, acc);
    i_SEL = CH_C;
    do_reset("rst_mid");
    idle("post_rst", 4'b0000, 1);

    // Random traffic with independently stalling consumers.
    for (int i = 0; i < 400; i++)
      step("rnd", 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
           32'($urandom), 4'($urandom_range(0, 15)), acc);
    idle("rnd_drain", 4'b1111, 4);

`ifdef DEMUX4_CNT_EN
    // Counter wrap on channel D: 65537 pops leave it at 1.
    do_reset("rst_cnt");
    begin
      int guard = 0;
      while ((cnt_m[3] != 16'd1 || guard < 1000) && guard < 70000) begin
        step("cnt", 1'b1, CH_D, 32'(guard), 4'b1000, acc);
        guard++;
      end
    end
    idle("cnt_stop", 4'b0000, 1);
    check("cnt_d_wrap", o_count, 64'h0001_0000_0000_0000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
